// File: rtl/mem2wb_queue.sv
// -----------------------------------------------------------------------------
// mem2wb_queue
//
// Elastic MEM->WB buffer: a DEPTH-entry first-word-fall-through FIFO between
// the Memory stage (producer) and the Write-Back stage (consumer). It also has
// a synchronous flush and a combinational GPR forwarding lookup over every
// buffered entry.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. A producer with valid=1 and ready=0 holds its payload
// stable. The queue holds out_payload_o stable while out_valid_o=1 and
// out_ready_i=0. in_ready_o and out_valid_o come from registered occupancy
// only, so neither side's ready/valid feeds the other combinationally.
//
// Payload layout, MSB to LSB: exe_out, op3, rd, gpr_ctrl, csr_ctrl, mem_ctrl.
// gpr_ctrl[0] is the GPR write enable.
//
// Ports:
//   clk_i          core clock, rising edge
//   rst_i          asynchronous active-high reset (clears entries and storage)
//   flush_i        synchronous flush of all entries (wins over push and pop)
//   in_valid_i     MEM offers a payload
//   in_ready_o     queue can accept a payload (not full)
//   in_payload_i   MEM->WB payload
//   out_valid_o    head entry is valid (not empty)
//   out_ready_i    WB consumes the head entry
//   out_payload_o  head entry payload
//   count_o        occupancy
//   fwd_rs_i       source register to look up
//   fwd_hit_o      a buffered entry will write fwd_rs_i
//   fwd_data_o     exe_out of the youngest matching entry, 0 when no hit
// -----------------------------------------------------------------------------
module mem2wb_queue #(
  parameter int DATA_WIDTH     = 32,
  parameter int RF_ADDR_WIDTH  = 5,
  parameter int GPR_CTRL_WIDTH = 2,
  parameter int CSR_CTRL_WIDTH = 3,
  parameter int MEM_CTRL_WIDTH = 4,
  parameter int DEPTH          = 4,
  parameter int PAYLOAD_WIDTH  = 2*DATA_WIDTH + RF_ADDR_WIDTH + GPR_CTRL_WIDTH
                                 + CSR_CTRL_WIDTH + MEM_CTRL_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [PAYLOAD_WIDTH-1:0]     in_payload_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [PAYLOAD_WIDTH-1:0]     out_payload_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  input  logic [RF_ADDR_WIDTH-1:0]     fwd_rs_i,
  output logic                         fwd_hit_o,
  output logic [DATA_WIDTH-1:0]        fwd_data_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  // Bit positions of the fields the forwarding lookup needs.
  localparam int GPR_LSB = MEM_CTRL_WIDTH + CSR_CTRL_WIDTH;
  localparam int RD_LSB  = GPR_LSB + GPR_CTRL_WIDTH;
  localparam int EXE_LSB = PAYLOAD_WIDTH - DATA_WIDTH;

  logic [PAYLOAD_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;

  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_fwd_hit;
  logic [DATA_WIDTH-1:0]    w_fwd_data;
  logic [PAYLOAD_WIDTH-1:0] w_ent;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A full queue refuses a push even if the head pops in the same cycle.
  // This keeps in_ready_o free of any path from out_ready_i.
  assign w_push = in_valid_i && !w_full;
  assign w_pop  = out_ready_i && !w_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      // Storage is left alone; only the bookkeeping is cleared.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_payload_i;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Forwarding: walk the entries from oldest (rd_ptr) to youngest, so a later
  // match overrides an earlier one and the youngest writer wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_ent      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ent = r_mem[r_rd_ptr + PTR_W'(i)];
      if ((CNT_W'(i) < r_count) && w_ent[GPR_LSB] &&
          (w_ent[RD_LSB +: RF_ADDR_WIDTH] == fwd_rs_i) &&
          (fwd_rs_i != '0)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_ent[EXE_LSB +: DATA_WIDTH];
      end
    end
  end

  assign in_ready_o    = !w_full;
  assign out_valid_o   = !w_empty;
  assign out_payload_o = r_mem[r_rd_ptr];
  assign count_o       = r_count;
  assign fwd_hit_o     = w_fwd_hit;
  assign fwd_data_o    = w_fwd_data;

endmodule

// File: tb/tb_mem2wb_queue.sv
// -----------------------------------------------------------------------------
// tb_mem2wb_queue
//
// Bench for mem2wb_queue. The reference model is a queue of accepted payloads
// (exp_q). Its size gives the expected occupancy. Its front is the expected
// head. A scan of its contents gives the expected forwarding result. A monitor
// on the falling edge compares the DUT against the model and then advances the
// model by the handshake that the next rising edge will complete.
// -----------------------------------------------------------------------------
module tb_mem2wb_queue;

  localparam int DW    = 32;
  localparam int RFW   = 5;
  localparam int GPRW  = 2;
  localparam int CSRW  = 3;
  localparam int MEMW  = 4;
  parameter  int DEPTH = 4;
  localparam int PW    = 2*DW + RFW + GPRW + CSRW + MEMW;
  localparam int CNTW  = $clog2(DEPTH+1);
  localparam int GPR_LSB = MEMW + CSRW;
  localparam int RD_LSB  = GPR_LSB + GPRW;
  localparam int EXE_LSB = PW - DW;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [PW-1:0]   in_payload_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [PW-1:0]   out_payload_o;
  logic [CNTW-1:0] count_o;
  logic [RFW-1:0]  fwd_rs_i = '0;
  logic            fwd_hit_o;
  logic [DW-1:0]   fwd_data_o;

  always #5 clk = ~clk;

  mem2wb_queue #(
    .DATA_WIDTH(DW), .RF_ADDR_WIDTH(RFW), .GPR_CTRL_WIDTH(GPRW),
    .CSR_CTRL_WIDTH(CSRW), .MEM_CTRL_WIDTH(MEMW), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_payload_i(in_payload_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_payload_o(out_payload_o),
    .count_o(count_o), .fwd_rs_i(fwd_rs_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o)
  );

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest accepted entry that writes rs, or no hit.
  task automatic fwd_model(input logic [RFW-1:0] rs, output logic hit, output logic [DW-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (rs != '0) begin
      foreach (exp_q[k]) begin
        if (exp_q[k][GPR_LSB] && exp_q[k][RD_LSB +: RFW] == rs) begin
          hit  = 1'b1;
          data = exp_q[k][EXE_LSB +: DW];
        end
      end
    end
  endtask

  always @(negedge clk) begin
    logic          m_hit;
    logic [DW-1:0] m_data;
    bit            m_push;
    bit            m_pop;
    if (mon_en && !rst_i) begin
      check("count", 128'(count_o), 128'(exp_q.size()));
      check("in_ready", 128'(in_ready_o), 128'(exp_q.size() != DEPTH));
      check("out_valid", 128'(out_valid_o), 128'(exp_q.size() != 0));
      fwd_model(fwd_rs_i, m_hit, m_data);
      check("fwd_hit", 128'(fwd_hit_o), 128'(m_hit));
      check("fwd_data", 128'(fwd_data_o), 128'(m_data));
      m_pop  = out_ready_i && (exp_q.size() != 0);
      m_push = in_valid_i && (exp_q.size() != DEPTH);
      if (m_pop) check("head_payload", 128'(out_payload_o), 128'(exp_q[0]));
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (m_pop)  void'(exp_q.pop_front());
        if (m_push) exp_q.push_back(in_payload_i);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] mk(input logic [DW-1:0] exe, input logic [RFW-1:0] rd,
                                       input logic [GPRW-1:0] gpr);
    logic [DW-1:0]   op3;
    logic [CSRW-1:0] csr;
    logic [MEMW-1:0] mem;
    op3 = $urandom;
    csr = CSRW'($urandom);
    mem = MEMW'($urandom);
    return {exe, op3, rd, gpr, csr, mem};
  endfunction

  task automatic push_one(input logic [PW-1:0] p);
    in_valid_i   = 1'b1;
    in_payload_i = p;
    cyc();
    in_valid_i   = 1'b0;
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) cyc();
    out_ready_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready_o), 128'(1));
    check({tag, "_out_valid"}, 128'(out_valid_o), 128'(0));
    check({tag, "_payload"}, 128'(out_payload_o), 128'(0));
    check({tag, "_count"}, 128'(count_o), 128'(0));
    check({tag, "_fwd_hit"}, 128'(fwd_hit_o), 128'(0));
    check({tag, "_fwd_data"}, 128'(fwd_data_o), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PW-1:0] p;

    // Reset then idle.
    rst_i = 1'b1;
    cyc(); cyc();
    rst_i = 1'b0;
    cyc();
    check_idle("reset");
    mon_en = 1'b1;

    // Fill to full with out_ready_i low; a 5th push is refused.
    for (int k = 0; k < DEPTH; k++) push_one(mk(DW'((k + 1) * 32'h11), RFW'(k + 1), 2'b01));
    check("full_count", 128'(count_o), 128'(DEPTH));
    check("full_in_ready", 128'(in_ready_o), 128'(0));
    push_one(mk(32'h55, 5'd9, 2'b01));
    check("refused_count", 128'(count_o), 128'(DEPTH));
    out_ready_i = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check("order_head", 128'(out_payload_o[EXE_LSB +: DW]), 128'((k + 1) * 32'h11));
      cyc();
    end
    out_ready_i = 1'b0;
    check("drained_valid", 128'(out_valid_o), 128'(0));

    // Streaming at occupancy 2 for 20 cycles.
    push_one(mk(32'h100, 5'd1, 2'b00));
    push_one(mk(32'h101, 5'd1, 2'b00));
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_payload_i = mk(DW'(32'h200 + k), RFW'($urandom), 2'($urandom));
      cyc();
      check("stream_count", 128'(count_o), 128'(2));
    end
    in_valid_i  = 1'b0;
    drain();

    // Full plus concurrent push and pop: push refused, occupancy drops.
    for (int k = 0; k < DEPTH; k++) push_one(mk(DW'(32'h300 + k), 5'd2, 2'b00));
    in_valid_i   = 1'b1;
    in_payload_i = mk(32'h3FF, 5'd2, 2'b00);
    out_ready_i  = 1'b1;
    cyc();
    in_valid_i   = 1'b0;
    out_ready_i  = 1'b0;
    check("full_pushpop_count", 128'(count_o), 128'(DEPTH - 1));
    drain();

    // Forwarding: youngest enabled writer wins; rs=0 never hits.
    push_one(mk(32'hA, 5'd5, 2'b01));
    push_one(mk(32'hB, 5'd5, 2'b11));
    push_one(mk(32'hC, 5'd5, 2'b10));
    if (DEPTH > 3) push_one(mk(32'hD, 5'd0, 2'b01));
    fwd_rs_i = 5'd5;
    #1;
    check("fwd5_hit", 128'(fwd_hit_o), 128'(1));
    check("fwd5_data", 128'(fwd_data_o), 128'(32'hB));
    fwd_rs_i = 5'd0;
    #1;
    check("fwd0_hit", 128'(fwd_hit_o), 128'(0));
    check("fwd0_data", 128'(fwd_data_o), 128'(0));
    fwd_rs_i = 5'd5;
    out_ready_i = 1'b1;
    cyc(); cyc();
    out_ready_i = 1'b0;
    check("fwd_after_pop_hit", 128'(fwd_hit_o), 128'(0));
    drain();

    // Flush with 3 entries plus concurrent push and pop.
    push_one(mk(32'h41, 5'd7, 2'b01));
    push_one(mk(32'h42, 5'd7, 2'b01));
    push_one(mk(32'h43, 5'd7, 2'b01));
    fwd_rs_i = 5'd7;
    #1;
    check("preflush_hit", 128'(fwd_hit_o), 128'(1));
    flush_i      = 1'b1;
    in_valid_i   = 1'b1;
    in_payload_i = mk(32'h44, 5'd7, 2'b01);
    out_ready_i  = 1'b1;
    cyc();
    flush_i      = 1'b0;
    in_valid_i   = 1'b0;
    out_ready_i  = 1'b0;
    check("flush_count", 128'(count_o), 128'(0));
    check("flush_valid", 128'(out_valid_o), 128'(0));
    check("flush_hit", 128'(fwd_hit_o), 128'(0));
    p = mk(32'h45, 5'd3, 2'b01);
    push_one(p);
    check("postflush_valid", 128'(out_valid_o), 128'(1));
    check("postflush_payload", 128'(out_payload_o), 128'(p));
    drain();

    // Asynchronous reset mid-stream with 3 entries.
    push_one(mk(32'h61, 5'd4, 2'b01));
    push_one(mk(32'h62, 5'd4, 2'b01));
    push_one(mk(32'h63, 5'd4, 2'b01));
    fwd_rs_i = 5'd4;
    #2;
    mon_en = 1'b0;
    rst_i  = 1'b1;
    #1;
    check_idle("async_rst");
    exp_q.delete();
    cyc();
    rst_i  = 1'b0;
    mon_en = 1'b1;
    cyc();

    // Randomized traffic: producer-heavy, then consumer-heavy, rare flushes.
    for (int c = 0; c < 10000; c++) begin
      // Hold the offered payload while it is being refused.
      if (!(in_valid_i && !in_ready_o)) begin
        in_valid_i   = (c < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        in_payload_i = mk($urandom, RFW'($urandom_range(0, 7)), 2'($urandom));
      end
      out_ready_i = (c < 5000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 99) == 0);
      fwd_rs_i    = RFW'($urandom_range(0, 7));
      cyc();
    end
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    drain();
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
